irq_requester: RTL

//  Interrupt source side of the CPU's 3-bit vectored IRQ interface. Collects up to seven

---
 rtl/irq_requester_if.sv | 22 ++
 rtl/irq_requester.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/irq_requester_if.sv
// Bundle of the peripheral request lines, the CPU's IRQ signals and the register port.
// The master modport is the CPU/peripheral side; the slave modport is the requester.
interface irq_requester_if;
  logic [6:0]  src;
  logic        eirq;
  logic [2:0]  irq_code;
  logic        irq_busy;
  logic        wr;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (
    output src, eirq, wr, addr, wdata,
    input  irq_code, irq_busy, rdata
  );

  modport slave (
    input  src, eirq, wr, addr, wdata,
    output irq_code, irq_busy, rdata
  );
endinterface

// File: rtl/irq_requester.sv
// Interrupt source for the CPU's 3-bit vectored IRQ input. Latches up to seven
// peripheral requests, issues the highest-index unmasked pending one as code i+1,
// holds it until end-of-interrupt, then forces one all-zero GAP cycle before the
// next issue.
//
//  state  | meaning
//  IDLE   | no code on the bus; issue the highest unmasked pending source
//  REQ    | irq_code held for source r_cur until eirq
//  GAP    | one cycle of irq_code=0 so the CPU sees a clean all-zero code
module irq_requester #(
  parameter int          NSRC      = 7,
  parameter logic [6:0]  EDGE_MASK = 7'h7F
) (
  input logic            clk,
  input logic            rst,
  irq_requester_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Valid-source mask: bits at and above NSRC are tied off everywhere.
  localparam logic [7:0] SRC_ONES  = 8'hFF >> (8 - NSRC);
  localparam logic [6:0] SRC_VALID = SRC_ONES[6:0];

  state_t      r_state;
  logic [2:0]  r_cur;
  logic [2:0]  r_irq_code;
  logic        r_irq_busy;
  logic [6:0]  r_src_q;
  logic [6:0]  r_mask;
  logic [6:0]  r_pending;
  logic        r_err;

  state_t      w_state_nxt;
  logic [2:0]  w_cur_nxt;
  logic [2:0]  w_code_nxt;
  logic        w_busy_nxt;
  logic        w_eoi;
  logic        w_err_set;
  logic [2:0]  w_hi;
  logic [6:0]  w_active;
  logic [6:0]  w_set;
  logic [6:0]  w_force;
  logic [6:0]  w_clr_sw;
  logic [6:0]  w_clr;
  logic [6:0]  w_cur_onehot;
  logic [6:0]  w_pend_nxt;
  logic        w_wr_mask;
  logic        w_wr_pend;
  logic        w_wr_stat;
  logic        w_wr_force;
  logic        w_unused;

  assign w_unused   = ^bus.wdata[14:7];

  assign w_wr_mask  = bus.wr && (bus.addr == 2'd0);
  assign w_wr_pend  = bus.wr && (bus.addr == 2'd1);
  assign w_wr_stat  = bus.wr && (bus.addr == 2'd2);
  assign w_wr_force = bus.wr && (bus.addr == 2'd3);

  assign w_active     = r_pending & r_mask & SRC_VALID;
  assign w_cur_onehot = 7'b1 << r_cur;

  // Request detection: edge sources fire on a rising transition, level sources
  // every cycle they are high; software FORCE writes add to the same set vector.
  always_comb begin
    w_force = w_wr_force ? bus.wdata[6:0] : 7'd0;
    w_set   = ((bus.src & ~r_src_q & EDGE_MASK) | (bus.src & ~EDGE_MASK) | w_force)
              & SRC_VALID;
  end

  // Pending clear sources: software W1C (except the bit in service) and end-of-interrupt.
  // Sets are OR-ed in after clears so a coincident set always wins.
  always_comb begin
    w_clr_sw = w_wr_pend ? bus.wdata[6:0] : 7'd0;
    if (r_state == S_REQ) begin
      w_clr_sw = w_clr_sw & ~w_cur_onehot;
    end
    w_clr      = w_clr_sw | (w_eoi ? w_cur_onehot : 7'd0);
    w_pend_nxt = ((r_pending & ~w_clr) | w_set) & SRC_VALID;
  end

  // FSM next-state and registered-output values.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_code_nxt  = r_irq_code;
    w_busy_nxt  = r_irq_busy;
    w_eoi       = 1'b0;
    w_err_set   = 1'b0;
    w_hi        = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (w_active[i]) begin
        w_hi = 3'(i);
      end
    end
    case (r_state)
      S_IDLE: begin
        w_err_set = bus.eirq;
        if (|w_active) begin
          w_state_nxt = S_REQ;
          w_cur_nxt   = w_hi;
          w_code_nxt  = w_hi + 3'd1;
          w_busy_nxt  = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.eirq) begin
          w_eoi       = 1'b1;
          w_state_nxt = S_GAP;
          w_code_nxt  = 3'd0;
          w_busy_nxt  = 1'b0;
        end
      end
      S_GAP: begin
        w_err_set   = bus.eirq;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_code_nxt  = 3'd0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state and the code/busy outputs; reset drops irq_code immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cur      <= 3'd0;
      r_irq_code <= 3'd0;
      r_irq_busy <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur      <= w_cur_nxt;
      r_irq_code <= w_code_nxt;
      r_irq_busy <= w_busy_nxt;
    end
  end

  // Request history and pending latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_q   <= 7'd0;
      r_pending <= 7'd0;
    end else begin
      r_src_q   <= bus.src & SRC_VALID;
      r_pending <= w_pend_nxt;
    end
  end

  // Software mask and sticky error (a new error beats a coincident clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= 7'd0;
      r_err  <= 1'b0;
    end else begin
      if (w_wr_mask) begin
        r_mask <= bus.wdata[6:0] & SRC_VALID;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_wr_stat && bus.wdata[15]) begin
        r_err <= 1'b0;
      end
    end
  end

  // Combinational register read-back.
  always_comb begin
    case (bus.addr)
      2'd0:    bus.rdata = {9'd0, r_mask};
      2'd1:    bus.rdata = {9'd0, r_pending};
      2'd2:    bus.rdata = {r_err, 9'd0, r_state, 1'b0, r_irq_code};
      default: bus.rdata = 16'd0;
    endcase
  end

  assign bus.irq_code = r_irq_code;
  assign bus.irq_busy = r_irq_busy;

endmodule
